fetch_stage: RTL and testbench

- Instruction-fetch stage plus the IF/ID pipeline register of the LEGv8 pipeline.
- Owns the PC and issues requests to a synchronous instruction memory.
- Presents the registered 32-bit instruction and its PC to the decode stage, where the immediate sign extender and the register file consume it.
- Handles hazard-unit stalls and branch/CBZ redirects. A one-entry hold buffer ensures no in-flight instruction is lost.

---
 rtl/arki_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 42 ++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/arki_pkg.sv
// Shared types and constants for the LEGv8 fetch stage: FSM states,
// datapath widths and the {instr, pc} packet carried by IF/ID and the hold buffer.
package arki_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks an in-flight fetch response while decode is stalled.
// Clear wins over load so a flush always empties the entry.
module fetch_hold_buf
    import arki_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch plus IF/ID register: PC, synchronous imem requests,
// stall handling via a one-entry hold buffer, and branch/CBZ redirect flush.
module fetch_stage #(
    parameter int               PC_W     = arki_pkg::PC_W,
    parameter int               INSTR_W  = arki_pkg::INSTR_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_W-1:0]       redirect_pc_i,
    output logic                  imem_req_o,
    output logic [PC_W-1:0]       imem_addr_o,
    input  logic [INSTR_W-1:0]    imem_rdata_i,
    output logic [INSTR_W-1:0]    ifid_instr_o,
    output logic [PC_W-1:0]       ifid_pc_o,
    output logic                  ifid_valid_o,
    output arki_pkg::fetch_state_t state_o
);

    import arki_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            resp_pending_q, resp_pending_d;
    fetch_pkt_t      ifid_q, ifid_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic            fetch;
    logic            buf_load;
    logic            buf_clear;
    logic            buf_valid;
    fetch_pkt_t      buf_pkt;
    fetch_pkt_t      resp_pkt;

    always_comb begin
        resp_pkt       = '0;
        resp_pkt.instr = imem_rdata_i;
        resp_pkt.pc    = req_pc_q;
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pkt_i   (resp_pkt),
        .valid_o (buf_valid),
        .pkt_o   (buf_pkt)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        resp_pending_d = resp_pending_q;
        ifid_d         = ifid_q;
        ifid_valid_d   = ifid_valid_q;
        fetch          = 1'b0;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;

        // A redirect flushes everything in flight, even a parked buffer entry.
        if (redirect_i) begin
            pc_d           = {redirect_pc_i[PC_W-1:2], 2'b00};
            ifid_valid_d   = 1'b0;
            resp_pending_d = 1'b0;
            buf_clear      = 1'b1;
            state_d        = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (stall_i) begin
                        if (resp_pending_q) begin
                            buf_load       = 1'b1;
                            resp_pending_d = 1'b0;
                            state_d        = HOLD;
                        end
                    end else begin
                        fetch        = 1'b1;
                        ifid_valid_d = resp_pending_q;
                        if (resp_pending_q) begin
                            ifid_d = resp_pkt;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        fetch        = 1'b1;
                        ifid_d       = buf_pkt;
                        ifid_valid_d = buf_valid;
                        buf_clear    = 1'b1;
                        state_d      = RUN;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        if (fetch) begin
            pc_d           = pc_q + PC_W'(PC_STEP);
            req_pc_d       = pc_q;
            resp_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            resp_pending_q <= 1'b0;
            ifid_q         <= '0;
            ifid_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            resp_pending_q <= resp_pending_d;
            ifid_q         <= ifid_d;
            ifid_valid_q   <= ifid_valid_d;
        end
    end

    assign imem_req_o   = fetch && !reset;
    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_valid_o = ifid_valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a synchronous imem model returns
// 32'h9100_0420 | addr[9:2]; every cycle's outputs are checked against hand values.
module tb_fetch_stage;

    import arki_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic         imem_req;
    logic [63:0]  imem_addr;
    logic [31:0]  imem_rdata = '0;
    logic [31:0]  ifid_instr;
    logic [63:0]  ifid_pc;
    logic         ifid_valid;
    fetch_state_t state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = -2;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc_o     (ifid_pc),
        .ifid_valid_o  (ifid_valid),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h9100_0420 | {24'h0, imem_addr[9:2]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, obs, exp);
        end
    endtask

    // Drive this cycle's inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [63:0] rpc);
        @(negedge clk);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        cyc_n++;
    endtask

    task automatic exp_req(input logic req, input logic [63:0] addr);
        check("imem_req", 64'(imem_req), 64'(req));
        check("imem_addr", imem_addr, addr);
    endtask

    task automatic exp_ifid(input logic v, input logic [63:0] pc, input logic [31:0] instr);
        check("ifid_valid", 64'(ifid_valid), 64'(v));
        check("ifid_pc", ifid_pc, pc);
        check("ifid_instr", 64'(ifid_instr), 64'(instr));
    endtask

    task automatic exp_bubble();
        check("ifid_valid", 64'(ifid_valid), 64'd0);
    endtask

    task automatic exp_state(input fetch_state_t s);
        check("state", 64'(state), 64'(s));
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);

        // Reset release and steady fetch.
        cyc(0, 0, 0, 0); exp_state(BOOT); exp_req(0, 64'h0); exp_ifid(0, 64'h0, 32'h0);
        cyc(0, 0, 0, 0); exp_state(RUN);  exp_req(1, 64'h0); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h4); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h8); exp_ifid(1, 64'h0, 32'h9100_0420);

        // Three-cycle stall with the 0x8 response in flight.
        cyc(0, 1, 0, 0); exp_state(RUN);  exp_req(0, 64'hC); exp_ifid(1, 64'h4, 32'h9100_0421);
        cyc(0, 1, 0, 0); exp_state(HOLD); exp_req(0, 64'hC); exp_ifid(1, 64'h4, 32'h9100_0421);
        cyc(0, 1, 0, 0); exp_state(HOLD); exp_req(0, 64'hC); exp_ifid(1, 64'h4, 32'h9100_0421);
        cyc(0, 0, 0, 0); exp_state(HOLD); exp_req(1, 64'hC); exp_ifid(1, 64'h4, 32'h9100_0421);
        cyc(0, 0, 0, 0); exp_req(1, 64'h10); exp_ifid(1, 64'h8, 32'h9100_0422);

        // Redirect to 0x40 while the 0x10 response is arriving.
        cyc(0, 0, 1, 64'h40); exp_req(0, 64'h14); exp_ifid(1, 64'hC, 32'h9100_0423);
        cyc(0, 0, 0, 0); exp_state(RUN); exp_req(1, 64'h40); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h44); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h48); exp_ifid(1, 64'h40, 32'h9100_0430);

        // Enter HOLD, then redirect and stall together.
        cyc(0, 1, 0, 0);      exp_req(0, 64'h4C); exp_ifid(1, 64'h44, 32'h9100_0431);
        cyc(0, 1, 1, 64'h80); exp_state(HOLD); exp_req(0, 64'h4C);
        cyc(0, 1, 0, 0);      exp_state(RUN);  exp_req(0, 64'h80); exp_bubble();
        cyc(0, 0, 0, 0);      exp_req(1, 64'h80); exp_bubble();
        cyc(0, 0, 0, 0);      exp_req(1, 64'h84); exp_bubble();

        // Misaligned redirect target is forced to word alignment.
        cyc(0, 0, 1, 64'h43); exp_req(0, 64'h88); exp_ifid(1, 64'h80, 32'h9100_0420);
        cyc(0, 0, 0, 0); exp_req(1, 64'h40); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h44); exp_bubble();

        // Redirect to the top of the address space; PC wraps to 0.
        cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC); exp_req(0, 64'h48); exp_ifid(1, 64'h40, 32'h9100_0430);
        cyc(0, 0, 0, 0); exp_req(1, 64'hFFFF_FFFF_FFFF_FFFC); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h0); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h4); exp_ifid(1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h9100_04FF);

        // Reset for one cycle while in HOLD.
        cyc(0, 1, 0, 0); exp_req(0, 64'h8); exp_ifid(1, 64'h0, 32'h9100_0420);
        cyc(1, 1, 0, 0); exp_state(HOLD);
        cyc(0, 0, 0, 0); exp_state(BOOT); exp_req(0, 64'h0); exp_ifid(0, 64'h0, 32'h0);
        cyc(0, 0, 0, 0); exp_state(RUN);  exp_req(1, 64'h0); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h4); exp_bubble();
        cyc(0, 0, 0, 0); exp_req(1, 64'h8); exp_ifid(1, 64'h0, 32'h9100_0420);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
